// File: rtl/wb_pkg.sv
// Shared types for the Wishbone burst scratch-memory slave:
// cycle/burst type encodings, FSM states and the wrap-mask helper.
package wb_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HOLD  = 2'b01,
        BURST = 2'b10
    } state_e;

    localparam int BEAT_W = 5;

    function automatic logic [3:0] wrap_mask(bte_e b);
        logic [3:0] m;
        unique case (b)
            LINEAR: m = 4'h0;
            WRAP4:  m = 4'h3;
            WRAP8:  m = 4'h7;
            WRAP16: m = 4'hf;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/wb_burst_slave_if.sv
// Wishbone B4 slave-side bus bundle with registered-feedback
// burst signals (CTI/BTE) and the read-sum tag request.
interface wb_burst_slave_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
) ();
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic [2:0]            cti_i;
    logic [1:0]            bte_i;
    logic                  tag_sum_i;
    logic                  ack_o;
    logic                  err_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [4:0]            beat_o;

    modport master (
        output cyc_i, stb_i, we_i, addr_i, data_i,
        output sel_i, cti_i, bte_i, tag_sum_i,
        input  ack_o, err_o, data_o, beat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, addr_i, data_i,
        input  sel_i, cti_i, bte_i, tag_sum_i,
        output ack_o, err_o, data_o, beat_o
    );
endinterface

// File: rtl/wb_burst_addr_gen.sv
// Beat counter and effective-address generator for linear/wrap
// bursts, with the depth-based out-of-range flag.
module wb_burst_addr_gen
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 48
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] base,
    input  bte_e                  bte,
    input  logic [2:0]            cti,
    input  logic                  restart,
    input  logic                  adv,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] eff_addr,
    output logic                  oor,
    output logic [BEAT_W-1:0]     beat
);
    localparam int EW = ADDR_WIDTH + BEAT_W;

    logic [BEAT_W-1:0] k_q, k_use, k_nxt;
    logic [EW-1:0]     base_x, mask_x, sum_x, eff;

    always_comb begin
        k_use  = restart ? '0 : k_q;
        base_x = EW'(base);
        mask_x = EW'(wrap_mask(bte));
        sum_x  = base_x + EW'(k_use);
        if (cti == CONST) begin
            eff = base_x;
        end else if (bte == LINEAR) begin
            eff = sum_x;
        end else begin
            eff = (base_x & ~mask_x) | (sum_x & mask_x);
        end
        oor      = eff >= EW'(DEPTH);
        eff_addr = eff[ADDR_WIDTH-1:0];
    end

    // The counter saturates so beat_o never wraps back to a small value.
    always_comb begin
        k_nxt = k_q;
        if (clr) begin
            k_nxt = '0;
        end else if (adv) begin
            k_nxt = (&k_use) ? k_use : k_use + 1'b1;
        end else if (restart) begin
            k_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q <= '0;
        end else begin
            k_q <= k_nxt;
        end
    end

    assign beat = k_q;

endmodule

// File: rtl/wb_burst_slave.sv
// Parametrised Wishbone B4 burst scratch memory with registered
// responses, depth range check and read-sum tag operation.
module wb_burst_slave
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int DEPTH      = 48,
    parameter int SUM_WORDS  = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    wb_burst_slave_if.slave bus
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, idx, base_mux;
    bte_e                  bte_q, bte_mux;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  req, first, issue, clr, oor;
    logic                  rsvd, tag_rd;
    logic                  ack_d, err_d, wr_en;
    logic                  ack_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_d, data_q;
    logic [DATA_WIDTH-1:0] sum_w, lane_m, rd_word;
    logic [BEAT_W-1:0]     beat;

    assign req   = bus.cyc_i & bus.stb_i;
    assign first = state_q == IDLE;
    assign issue = req & (state_q != HOLD);
    assign clr   = !bus.cyc_i | (state_q == HOLD);

    // Beat 0 is served straight from the bus; later beats use the latch.
    assign base_mux = first ? bus.addr_i : base_q;
    assign bte_mux  = first ? bte_e'(bus.bte_i) : bte_q;

    wb_burst_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_addr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .base     (base_mux),
        .bte      (bte_mux),
        .cti      (bus.cti_i),
        .restart  (first),
        .adv      (issue),
        .clr      (clr),
        .eff_addr (idx),
        .oor      (oor),
        .beat     (beat)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            bte_q   <= LINEAR;
        end else begin
            state_q <= state_d;
            if (first && req) begin
                base_q <= bus.addr_i;
                bte_q  <= bte_e'(bus.bte_i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.cyc_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.stb_i) begin
                        state_d = (bus.cti_i == INCR) ? BURST : HOLD;
                    end
                end
                HOLD:  state_d = IDLE;
                BURST: begin
                    if (bus.stb_i && bus.cti_i == EOB) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < SUM_WORDS; i++) begin
            sum_w = sum_w + mem[i];
        end
        for (int i = 0; i < SEL_WIDTH; i++) begin
            lane_m[8*i +: 8] = {8{bus.sel_i[i]}};
        end
        rd_word = oor ? '0 : mem[idx];
    end

    always_comb begin
        rsvd    = !(bus.cti_i inside {CLASSIC, CONST, INCR, EOB});
        tag_rd  = bus.tag_sum_i & !bus.we_i;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        rdata_d = '0;
        if (issue) begin
            if (rsvd || (oor && !tag_rd)) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                unique case (1'b1)
                    bus.we_i: wr_en   = 1'b1;
                    tag_rd:   rdata_d = sum_w;
                    default:  rdata_d = rd_word & lane_m;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ack_q  <= ack_d;
            err_q  <= err_d;
            data_q <= rdata_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (bus.sel_i[i]) begin
                    mem[idx][8*i +: 8] <= bus.data_i[8*i +: 8];
                end
            end
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.err_o  = err_q;
    assign bus.data_o = data_q;
    assign bus.beat_o = beat;

endmodule

// File: doc/wb_burst_slave.md
# wb_burst_slave

Parametrised Wishbone B4 registered-feedback memory slave, the next generation of the team's single-slave block. Depth, data width and byte-lane granularity are parameters. Adds linear and wrapping incrementing bursts (CTI/BTE), end-of-burst handling, a depth-derived range check and a configurable read-sum tag operation. It sits behind the bus interconnect as a general-purpose scratch memory.

## Interface
Parameters:
- ADDR_WIDTH, default 6: word address width.
- DATA_WIDTH, default 32: data width; must be a multiple of 8.
- SEL_WIDTH, default DATA_WIDTH/8: byte-select lanes.
- DEPTH, default 48: implemented words; must satisfy 2 ≤ DEPTH ≤ 2**ADDR_WIDTH.
- SUM_WORDS, default 2: number of words summed by a tag read; range 1..DEPTH.

Ports:
- clk_i, in, 1: clock. One clock only; all logic on its rising edge.
- rst_ni, in, 1: reset, asynchronous and active-low.
- cyc_i, in, 1: bus cycle.
- stb_i, in, 1: strobe.
- we_i, in, 1: write enable.
- addr_i, in, ADDR_WIDTH: word address (base address for bursts).
- data_i, in, DATA_WIDTH: write data.
- sel_i, in, SEL_WIDTH: byte lanes.
- cti_i, in, 3: cycle type; 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
- bte_i, in, 2: burst type; 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16.
- tag_sum_i, in, 1: read returns the sum of words 0..SUM_WORDS-1.
- ack_o, out, 1: beat acknowledged.
- err_o, out, 1: beat errored.
- data_o, out, DATA_WIDTH: read data.
- beat_o, out, 5: beats completed in the current burst (debug).

## Operation
- Reset (rst_ni low): ack_o=0, err_o=0, data_o=0, beat_o=0, FSM=IDLE. Memory contents are not reset.
- FSM has three states.
  - IDLE: on cyc_i&stb_i, latch base=addr_i, mode=cti_i/bte_i, issue beat 0. Go to BURST if cti_i=010, else to HOLD.
  - HOLD: classic/constant beat has been answered. ack_o/err_o are low this cycle. Return to IDLE.
  - BURST: each cycle with cyc_i&stb_i issues the next beat. A beat with cti_i=111 is the last; after it, go to IDLE.
- Burst exit and pause:
  - cyc_i low in any state: go to IDLE next cycle, beat counter cleared, no response.
  - stb_i low with cyc_i high in BURST: wait state; counter holds and no response is issued.
- Effective address for beat k (linear): base+k, computed at ADDR_WIDTH+5 bits with no truncation.
- Effective address for beat k (wrap-N): {base[hi:log2N], (base[log2N-1:0]+k) mod N}.
- cti_i=001 reuses base every beat. cti_i=010 after a 111 beat starts a new burst from IDLE.
- Range check: an effective address ≥ DEPTH is an error beat.
  - err_o=1, ack_o=0, no memory write, data_o=0.
  - The counter still advances.
- Reserved cti_i (011..110) is an error beat and is treated as classic.
- Write beat: for each set sel_i[i], byte i of mem[eff] takes data_i byte i. ack_o=1, data_o=0.
- Read beat: data_o bytes with sel set take mem[eff]; unselected bytes are 0. ack_o=1.
- Tag read (tag_sum_i & !we_i): data_o = sum of mem[0..SUM_WORDS-1], modulo 2**DATA_WIDTH, all lanes regardless of sel_i. ack_o=1, no range check. Tag with we_i=1 is ignored and the beat is a normal write.
- beat_o counts acked or errored beats in the current burst, saturating at 31. It clears in IDLE.

## Timing
- All outputs are registered. The response to a beat sampled at edge n is visible after edge n (one-cycle latency).
- Classic: request at cycle 0, ack at cycle 1, low at cycle 2. The next request is accepted at cycle 2.
- Incrementing burst: back-to-back ack every cycle while stb_i is high. Read data for beat k appears with its ack.
- Read-after-write to the same word in consecutive beats returns the new data. Memory write takes effect at the ack edge.
- Wait state in BURST: no ack the following cycle. Resume continues at the next k.
- rst_ni asserted mid-burst: outputs clear immediately (asynchronous). Any partially accepted write beat at that edge may or may not land.

## Structure
- Package wb_pkg holds:
  - cti_e enum (CLASSIC, CONST, INCR, EOB);
  - bte_e enum (LINEAR, WRAP4, WRAP8, WRAP16);
  - state_e (IDLE, HOLD, BURST);
  - a function computing the wrap mask from bte_e.
- Sub-module wb_burst_addr_gen takes base, bte, cti and the beat counter, and produces eff_addr and the out-of-range flag (combinational plus the counter register).
- Memory is an inferred array in the top module.

## Test plan
- Reset, then a classic write of 0xDEADBEEF to address 5 with sel=1111, then a read of address 5 → ack at cycle 1, data_o=0xDEADBEEF, and ack is low at cycle 2.
- Byte-lane write of 0x11223344 to address 7 with sel=0101 over 0, then a read with sel=1111 → data_o=0x00220044.
- Incrementing linear write burst of 4 beats from base 3, last beat cti=111 → ack high on 4 consecutive cycles. Reading back 3..6 returns the written data, and beat_o reaches 4.
- Wrap-4 read burst from base 6 → addresses 6, 7, 4, 5, in that order.
- Linear burst from base DEPTH-2 for 4 beats → ack, ack, err, err. No write beyond DEPTH-1.
- mem[0]=0xFFFFFFFF and mem[1]=2, then a tag_sum read with SUM_WORDS=2 → data_o=0x00000001.
- Separate check: drop cyc_i mid-burst → IDLE and no ack next cycle.
- Separate check: assert rst_ni low mid-burst → outputs are 0 immediately.
